// File: rtl/tt_um_jleugeri_ttt_token_accumulator.sv
// Per-processor good/bad token accumulator with saturating adds and a sequential
// fire sweep that reports and clears every processor over its thresholds.
module tt_um_jleugeri_ttt_token_accumulator #(
  parameter int unsigned NUM_PROCESSORS  = 8,
  parameter int unsigned NEW_TOKENS_BITS = 4,
  parameter int unsigned TOKEN_BITS      = 8,
  parameter int unsigned PROG_WIDTH      = 8,
  localparam int unsigned PID_W          = $clog2(NUM_PROCESSORS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 instruction,
  input  logic [PID_W-1:0]           processor_id,
  input  logic [PROG_WIDTH-1:0]      prog_data,
  input  logic                       in_valid,
  input  logic [PID_W-1:0]           in_target_id,
  input  logic [NEW_TOKENS_BITS-1:0] in_good_tokens,
  input  logic [NEW_TOKENS_BITS-1:0] in_bad_tokens,
  output logic                       busy,
  output logic                       fire_valid,
  output logic [PID_W-1:0]           fire_id,
  output logic                       sweep_done
);

  localparam logic [2:0] InstrSetGood = 3'b001;
  localparam logic [2:0] InstrSetBad  = 3'b010;
  localparam logic [2:0] InstrClear   = 3'b011;
  localparam logic [2:0] InstrSweep   = 3'b100;

  localparam logic [PID_W-1:0] LastIdx = PID_W'(NUM_PROCESSORS - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e                       state_q, state_d;
  logic [PID_W-1:0]             idx_q, idx_d;
  logic signed [TOKEN_BITS-1:0] good_q     [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] good_d     [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] bad_q      [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] bad_d      [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] good_thr_q [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] good_thr_d [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] bad_thr_q  [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] bad_thr_d  [NUM_PROCESSORS];
  logic                         fire_valid_q, fire_valid_d;
  logic [PID_W-1:0]             fire_id_q, fire_id_d;
  logic                         sweep_done_q, sweep_done_d;

  // One extra bit of headroom makes overflow visible as a top-two-bit mismatch.
  function automatic logic signed [TOKEN_BITS-1:0] sat_add(
    input logic signed [TOKEN_BITS-1:0]      acc,
    input logic signed [NEW_TOKENS_BITS-1:0] delta
  );
    logic signed [TOKEN_BITS:0]   sum;
    logic signed [TOKEN_BITS-1:0] res;
    sum = {acc[TOKEN_BITS-1], acc}
        + {{(TOKEN_BITS + 1 - NEW_TOKENS_BITS){delta[NEW_TOKENS_BITS-1]}}, delta};
    if (sum[TOKEN_BITS] != sum[TOKEN_BITS-1]) begin
      res = sum[TOKEN_BITS] ? {1'b1, {(TOKEN_BITS - 1){1'b0}}}
                            : {1'b0, {(TOKEN_BITS - 1){1'b1}}};
    end else begin
      res = sum[TOKEN_BITS-1:0];
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    good_d       = good_q;
    bad_d        = bad_q;
    good_thr_d   = good_thr_q;
    bad_thr_d    = bad_thr_q;
    fire_valid_d = 1'b0;
    fire_id_d    = fire_id_q;
    sweep_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          good_d[in_target_id] = sat_add(good_q[in_target_id], in_good_tokens);
          bad_d[in_target_id]  = sat_add(bad_q[in_target_id], in_bad_tokens);
        end
        case (instruction)
          InstrSetGood: good_thr_d[processor_id] = prog_data[TOKEN_BITS-1:0];
          InstrSetBad:  bad_thr_d[processor_id]  = prog_data[TOKEN_BITS-1:0];
          InstrClear: begin
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
              good_d[i] = '0;
              bad_d[i]  = '0;
            end
          end
          InstrSweep: begin
            state_d = StSweep;
            idx_d   = '0;
          end
          default: ;
        endcase
      end
      StSweep: begin
        if (good_q[idx_q] >= good_thr_q[idx_q] && bad_q[idx_q] < bad_thr_q[idx_q]) begin
          fire_valid_d  = 1'b1;
          fire_id_d     = idx_q;
          good_d[idx_q] = '0;
          bad_d[idx_q]  = '0;
        end
        idx_d = idx_q + PID_W'(1);
        if (idx_q == LastIdx) begin
          state_d      = StIdle;
          idx_d        = '0;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      fire_valid_q <= 1'b0;
      fire_id_q    <= '0;
      sweep_done_q <= 1'b0;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        good_q[i]     <= '0;
        bad_q[i]      <= '0;
        good_thr_q[i] <= '0;
        bad_thr_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fire_valid_q <= fire_valid_d;
      fire_id_q    <= fire_id_d;
      sweep_done_q <= sweep_done_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      good_thr_q   <= good_thr_d;
      bad_thr_q    <= bad_thr_d;
    end
  end

  assign busy       = (state_q == StSweep);
  assign fire_valid = fire_valid_q;
  assign fire_id    = fire_id_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_accumulator.sv
// Directed plus randomized bench; expectations come from an integer model of the
// counters and thresholds, with firing decided by plain signed comparisons.
module tb_tt_um_jleugeri_ttt_token_accumulator;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] instruction;
  logic [2:0] processor_id;
  logic [7:0] prog_data;
  logic       in_valid;
  logic [2:0] in_target_id;
  logic [3:0] in_good_tokens;
  logic [3:0] in_bad_tokens;
  logic       busy;
  logic       fire_valid;
  logic [2:0] fire_id;
  logic       sweep_done;

  int checks = 0;
  int errors = 0;
  int good_m [N];
  int bad_m  [N];
  int gthr_m [N];
  int bthr_m [N];

  tt_um_jleugeri_ttt_token_accumulator dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .processor_id   (processor_id),
    .prog_data      (prog_data),
    .in_valid       (in_valid),
    .in_target_id   (in_target_id),
    .in_good_tokens (in_good_tokens),
    .in_bad_tokens  (in_bad_tokens),
    .busy           (busy),
    .fire_valid     (fire_valid),
    .fire_id        (fire_id),
    .sweep_done     (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      good_m[i] = 0;
      bad_m[i]  = 0;
      gthr_m[i] = 0;
      bthr_m[i] = 0;
    end
  endtask

  task automatic model_add(input int t, input logic [3:0] g, input logic [3:0] b);
    good_m[t] = sat(good_m[t] + sx4(g));
    bad_m[t]  = sat(bad_m[t] + sx4(b));
  endtask

  task automatic idle_inputs();
    instruction    = 3'd0;
    processor_id   = 3'd0;
    prog_data      = 8'd0;
    in_valid       = 1'b0;
    in_target_id   = 3'd0;
    in_good_tokens = 4'd0;
    in_bad_tokens  = 4'd0;
  endtask

  // Instruction issued in IDLE, optionally together with a token delta.
  task automatic cmd(input logic [2:0] instr, input int pid, input logic [7:0] data,
                     input bit v, input int t, input logic [3:0] g, input logic [3:0] b);
    instruction    = instr;
    processor_id   = 3'(pid);
    prog_data      = data;
    in_valid       = v;
    in_target_id   = 3'(t);
    in_good_tokens = g;
    in_bad_tokens  = b;
    step();
    idle_inputs();
    if (v && instr != 3'd3) model_add(t, g, b);
    case (instr)
      3'd1: gthr_m[pid] = sx8(data);
      3'd2: bthr_m[pid] = sx8(data);
      3'd3: for (int i = 0; i < N; i++) begin good_m[i] = 0; bad_m[i] = 0; end
      default: ;
    endcase
  endtask

  task automatic tok(input int t, input logic [3:0] g, input logic [3:0] b);
    cmd(3'd0, 0, 8'd0, 1'b1, t, g, b);
  endtask

  task automatic prog(input logic [2:0] instr, input int pid, input logic [7:0] data);
    cmd(instr, pid, data, 1'b0, 0, 4'd0, 4'd0);
  endtask

  // Full sweep with random junk on the inputs while busy, which must be ignored.
  task automatic sweep(input bit v, input int t, input logic [3:0] g, input logic [3:0] b);
    bit exp_fire [N];
    cmd(3'd4, 0, 8'd0, v, t, g, b);
    for (int k = 0; k < N; k++)
      exp_fire[k] = (good_m[k] >= gthr_m[k]) && (bad_m[k] < bthr_m[k]);
    chk("busy_after_start", busy, 1);
    chk("fire_valid_after_start", fire_valid, 0);
    for (int k = 0; k < N; k++) begin
      instruction    = 3'($urandom_range(0, 7));
      processor_id   = 3'($urandom);
      prog_data      = 8'($urandom);
      in_valid       = 1'($urandom);
      in_target_id   = 3'($urandom);
      in_good_tokens = 4'($urandom);
      in_bad_tokens  = 4'($urandom);
      step();
      idle_inputs();
      chk($sformatf("fire_valid[%0d]", k), fire_valid, 32'(exp_fire[k]));
      if (exp_fire[k]) chk($sformatf("fire_id[%0d]", k), fire_id, k);
      chk($sformatf("sweep_done[%0d]", k), sweep_done, 32'(k == N - 1));
      chk($sformatf("busy[%0d]", k), busy, 32'(k != N - 1));
    end
    for (int k = 0; k < N; k++) begin
      if (exp_fire[k]) begin
        good_m[k] = 0;
        bad_m[k]  = 0;
      end
    end
    step();
    chk("fire_valid_post", fire_valid, 0);
    chk("sweep_done_post", sweep_done, 0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_fire_valid", fire_valid, 0);
    chk("rst_fire_id", fire_id, 0);
    chk("rst_sweep_done", sweep_done, 0);
    reset = 1'b0;
    step();

    // Unprogrammed: nothing fires.
    sweep(1'b0, 0, 4'd0, 4'd0);

    // Two +2 deltas reach the threshold of 3.
    prog(3'd1, 2, 8'd3);
    prog(3'd2, 2, 8'd1);
    tok(2, 4'd2, 4'd0);
    tok(2, 4'd2, 4'd0);
    sweep(1'b0, 0, 4'd0, 4'd0);
    sweep(1'b0, 0, 4'd0, 4'd0);

    // Positive and negative saturation on proc 1.
    prog(3'd2, 1, 8'd1);
    prog(3'd1, 1, 8'd127);
    for (int i = 0; i < 20; i++) tok(1, 4'd7, 4'd0);
    sweep(1'b0, 0, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) tok(1, 4'd7, 4'd0);
    tok(1, 4'h8, 4'd0);
    prog(3'd1, 1, 8'd120);
    sweep(1'b0, 0, 4'd0, 4'd0);
    prog(3'd1, 1, 8'd119);
    sweep(1'b0, 0, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) tok(1, 4'h8, 4'd0);
    prog(3'd1, 1, 8'h81);
    sweep(1'b0, 0, 4'd0, 4'd0);
    prog(3'd1, 1, 8'h80);
    sweep(1'b0, 0, 4'd0, 4'd0);

    // Bad-token gating on proc 3.
    tok(3, 4'd5, 4'd1);
    prog(3'd1, 3, 8'd4);
    prog(3'd2, 3, 8'd1);
    sweep(1'b0, 0, 4'd0, 4'd0);
    tok(3, 4'd0, 4'hF);
    sweep(1'b0, 0, 4'd0, 4'd0);

    // Clear beats a simultaneous delta; sweep start keeps its delta.
    prog(3'd1, 0, 8'd4);
    prog(3'd2, 0, 8'd1);
    cmd(3'd3, 0, 8'd0, 1'b1, 0, 4'd4, 4'd0);
    sweep(1'b0, 0, 4'd0, 4'd0);
    sweep(1'b1, 0, 4'd4, 4'd0);

    // Reserved opcodes behave as nop.
    tok(0, 4'd4, 4'd0);
    prog(3'd5, 0, 8'd100);
    prog(3'd6, 0, 8'd100);
    prog(3'd7, 0, 8'd100);
    sweep(1'b0, 0, 4'd0, 4'd0);

    // Randomized rounds.
    for (int r = 0; r < 10; r++) begin
      int n;
      n = int'($urandom_range(3, 12));
      for (int i = 0; i < 3; i++) begin
        int gv, bv;
        gv = int'($urandom_range(0, 20)) - 10;
        bv = int'($urandom_range(0, 15)) - 5;
        prog(3'd1, int'($urandom_range(0, 7)), gv[7:0]);
        prog(3'd2, int'($urandom_range(0, 7)), bv[7:0]);
      end
      for (int i = 0; i < n; i++)
        tok(int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      if (r == 4) cmd(3'd3, 0, 8'd0, 1'b1, 5, 4'd3, 4'd0);
      sweep(1'($urandom), int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    end

    // Reset while proc 3 is being evaluated; proc 3 would otherwise fire.
    tok(5, 4'd5, 4'd3);
    prog(3'd1, 3, 8'd0);
    prog(3'd2, 3, 8'd1);
    good_m[3] = 0;
    bad_m[3]  = 0;
    instruction = 3'd4;
    step();
    idle_inputs();
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fire_valid", fire_valid, 0);
    chk("mid_rst_fire_id", fire_id, 0);
    chk("mid_rst_sweep_done", sweep_done, 0);
    step();
    chk("mid_rst_no_done", sweep_done, 0);
    chk("mid_rst_idle", busy, 0);
    // With bad_thr=1 everywhere, every cleared counter fires.
    for (int i = 0; i < N; i++) prog(3'd2, i, 8'd1);
    sweep(1'b0, 0, 4'd0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
